// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped, write-back, write-allocate data cache with a
// blocking miss FSM. Valid/ready CPU port, req/ack line-wide memory port.
// Optional hit/miss/write-back counters when DCACHE_STATS_EN is defined.
// Line layout: word 0 sits in the MSBs of a line.
module data_cache_ctrl #(
  parameter int WORD_SIZE   = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 4,
  parameter int INDEX_BITS  = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_write,
  input  logic [ADDR_WIDTH-1:0]                 req_addr,
  input  logic [WORD_SIZE-1:0]                  req_wdata,
  output logic                                  resp_valid,
  output logic [WORD_SIZE-1:0]                  resp_rdata,
  output logic                                  mem_req,
  output logic                                  mem_we,
  output logic [ADDR_WIDTH-OFFSET_BITS-1:0]     mem_addr,
  output logic [WORD_SIZE*(1<<OFFSET_BITS)-1:0] mem_wblock,
  input  logic                                  mem_ack,
  input  logic [WORD_SIZE*(1<<OFFSET_BITS)-1:0] mem_rblock
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                           hit_count,
  output logic [31:0]                           miss_count,
  output logic [31:0]                           wb_count
`endif
);

  localparam int LINE_WORDS = 1 << OFFSET_BITS;
  localparam int LINE_BITS  = WORD_SIZE * LINE_WORDS;
  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int NUM_LINES  = 1 << INDEX_BITS;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_SIZE-1:0]  wdata;
  } req_t;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;

  state_t                  state;
  req_t                    req_q;
  logic [NUM_LINES-1:0]    valid_q;
  logic [NUM_LINES-1:0]    dirty_q;

  // Tag/data storage is deliberately not reset; valid_q guards it.
  logic [LINE_BITS-1:0]    data_mem [NUM_LINES];
  logic [TAG_BITS-1:0]     tag_mem  [NUM_LINES];

  logic [OFFSET_BITS-1:0]  req_off;
  logic [INDEX_BITS-1:0]   req_idx;
  logic [TAG_BITS-1:0]     req_tag;
  logic [LINE_BITS-1:0]    line_rd;
  logic [TAG_BITS-1:0]     tag_rd;
  logic                    hit;
  logic                    line_we;
  logic                    tag_we;
  logic [LINE_BITS-1:0]    line_wdata;
  logic [LINE_BITS-1:0]    fill_line;

  assign req_off = req_q.addr[OFFSET_BITS-1:0];
  assign req_idx = req_q.addr[OFFSET_BITS +: INDEX_BITS];
  assign req_tag = req_q.addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign line_rd = data_mem[req_idx];
  assign tag_rd  = tag_mem[req_idx];
  assign hit     = valid_q[req_idx] && (tag_rd == req_tag);

  function automatic logic [WORD_SIZE-1:0] get_word(input logic [LINE_BITS-1:0] line,
                                                    input logic [OFFSET_BITS-1:0] off);
    int unsigned sh;
    sh = (LINE_WORDS - 1 - int'(off)) * WORD_SIZE;
    return line[sh +: WORD_SIZE];
  endfunction

  function automatic logic [LINE_BITS-1:0] merge_word(input logic [LINE_BITS-1:0] line,
                                                      input logic [OFFSET_BITS-1:0] off,
                                                      input logic [WORD_SIZE-1:0]   w);
    logic [LINE_BITS-1:0] r;
    int unsigned          sh;
    r  = line;
    sh = (LINE_WORDS - 1 - int'(off)) * WORD_SIZE;
    r[sh +: WORD_SIZE] = w;
    return r;
  endfunction

  // Array write port: store hits merge in place, fills take the memory line
  // (with the store word merged in for write-allocate).
  always_comb begin
    fill_line  = req_q.write ? merge_word(mem_rblock, req_off, req_q.wdata) : mem_rblock;
    line_we    = ((state == LOOKUP) && hit && req_q.write) || ((state == FILL) && mem_ack);
    tag_we     = (state == FILL) && mem_ack;
    line_wdata = (state == FILL) ? fill_line : merge_word(line_rd, req_off, req_q.wdata);
  end

  // Tag and data arrays.
  always_ff @(posedge clk) begin
    if (line_we) data_mem[req_idx] <= line_wdata;
    if (tag_we)  tag_mem[req_idx]  <= req_tag;
  end

  // Miss FSM with registered outputs; reset abandons any memory transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wblock <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q     <= '{write: req_write, addr: req_addr, wdata: req_wdata};
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_q.write) dirty_q[req_idx] <= 1'b1;
            resp_rdata <= req_q.write ? '0 : get_word(line_rd, req_off);
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b1;
            mem_addr   <= {tag_rd, req_idx};
            mem_wblock <= line_rd;
            state      <= WB;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_idx};
            state    <= FILL;
          end
        end
        WB: begin
          // mem_req stays high straight into the fill.
          if (mem_ack) begin
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_idx};
            state    <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            mem_req          <= 1'b0;
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= req_q.write;
            resp_rdata       <= req_q.write ? '0 : get_word(mem_rblock, req_off);
            resp_valid       <= 1'b1;
            state            <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state == LOOKUP && hit && hit_count != '1)   hit_count  <= hit_count + 32'd1;
      if (state == LOOKUP && !hit && miss_count != '1) miss_count <= miss_count + 32'd1;
      if (state == WB && mem_ack && wb_count != '1)    wb_count   <= wb_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl with a behavioural line memory that
// answers mem_req after a programmable number of cycles.
module tb_data_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_write;
  logic         req_ready;
  logic [31:0]  req_addr, req_wdata;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         mem_req, mem_we, mem_ack;
  logic [27:0]  mem_addr;
  logic [511:0] mem_wblock, mem_rblock;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count, miss_count, wb_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // memory model state
  logic [511:0] model [logic [27:0]];
  int           ack_delay = 0;
  int           wait_cnt = 0;
  int           wb_seen = 0, fill_seen = 0;
  logic [27:0]  last_wb_addr = '0, last_fill_addr = '0;
  logic [511:0] last_wb_blk = '0;
  int           stray_req = 0, stray_done = 0;

  always #5 clk = ~clk;

  data_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wblock(mem_wblock), .mem_ack(mem_ack), .mem_rblock(mem_rblock)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  function automatic logic [511:0] pat_line(input logic [27:0] la);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[(15-k)*32 +: 32] = {4'hC, la[19:0], 8'(k)};
    return l;
  endfunction

  // memory responder, driven on the falling edge
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (stray_req != stray_done) begin
      mem_ack    = 1'b1;
      stray_done = stray_req;
      wait_cnt   = 0;
    end else if (rst || !mem_req) begin
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      mem_ack  = 1'b1;
      wait_cnt = 0;
      if (mem_we) begin
        model[mem_addr] = mem_wblock;
        wb_seen++;
        last_wb_addr = mem_addr;
        last_wb_blk  = mem_wblock;
      end else begin
        mem_rblock = model.exists(mem_addr) ? model[mem_addr] : pat_line(mem_addr);
        fill_seen++;
        last_fill_addr = mem_addr;
      end
    end else begin
      wait_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bounded wait for the response pulse; lat counts falling edges after accept
  task automatic wait_resp(input string tag, output logic [31:0] rdata, output int lat);
    bit got = 0;
    lat = 0;
    rdata = '0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        got = 1;
        rdata = resp_rdata;
        break;
      end
    end
    chk({tag, "_resp_seen"}, 512'(got), 512'd1);
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata, output int lat);
    bit acc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    for (int n = 0; n < 200; n++) begin
      if (req_ready) begin
        @(posedge clk);
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    #1 req_valid = 1'b0;
    chk({tag, "_accepted"}, 512'(acc), 512'd1);
    wait_resp(tag, rdata, lat);
  endtask

  initial begin
    logic [31:0]  rd;
    logic [511:0] blk;
    int           lat, fs, ws;
    bit           stable, acc;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_rblock = '0;
    blk = pat_line(28'h1);
    blk[511:480] = 32'hDEADBEEF;
    model[28'h1] = blk;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 512'(req_ready), 512'd1);
    chk("rst_resp_valid", 512'(resp_valid), 512'd0);
    chk("rst_resp_rdata", 512'(resp_rdata), 512'd0);
    chk("rst_mem_req", 512'(mem_req), 512'd0);
    chk("rst_mem_we", 512'(mem_we), 512'd0);
    chk("rst_mem_addr", 512'(mem_addr), 512'd0);
    chk("rst_mem_wblock", mem_wblock, 512'd0);
    rst = 1'b0;

    // T1: cold load miss
    do_req("t1", 1'b0, 32'h10, 32'h0, rd, lat);
    chk("t1_fill_addr", 512'(last_fill_addr), 512'h1);
    chk("t1_rdata", 512'(rd), 512'hDEADBEEF);
    chk("t1_no_wb", 512'(wb_seen), 512'd0);

    // T2: store hit then load hit, both 2-cycle latency
    fs = fill_seen;
    do_req("t2_st", 1'b1, 32'h13, 32'h12345678, rd, lat);
    chk("t2_st_rdata_zero", 512'(rd), 512'd0);
    chk("t2_st_lat", 512'(lat), 512'd2);
    @(negedge clk);
    chk("t2_pulse_one_cycle", 512'(resp_valid), 512'd0);
    chk("t2_ready_back", 512'(req_ready), 512'd1);
    do_req("t2_ld", 1'b0, 32'h13, 32'h0, rd, lat);
    chk("t2_ld_rdata", 512'(rd), 512'h12345678);
    chk("t2_ld_lat", 512'(lat), 512'd2);
    do_req("t2_ld0", 1'b0, 32'h10, 32'h0, rd, lat);
    chk("t2_ld0_rdata", 512'(rd), 512'hDEADBEEF);
    chk("t2_no_mem_traffic", 512'(fill_seen), 512'(fs));

    // T3: conflict miss on dirty line -> write-back then fill
    do_req("t3", 1'b0, 32'h4010, 32'h0, rd, lat);
    chk("t3_wb_count", 512'(wb_seen), 512'd1);
    chk("t3_wb_addr", 512'(last_wb_addr), 512'h001);
    blk = last_wb_blk;
    chk("t3_wb_word3", 512'(blk[415:384]), 512'h12345678);
    chk("t3_wb_word0", 512'(blk[511:480]), 512'hDEADBEEF);
    chk("t3_fill_addr", 512'(last_fill_addr), 512'h401);
    chk("t3_rdata", 512'(rd), 512'hC0040100);
`ifdef DCACHE_STATS_EN
    chk("t3_hit_count", 512'(hit_count), 512'd3);
    chk("t3_miss_count", 512'(miss_count), 512'd2);
    chk("t3_wb_stat", 512'(wb_count), 512'd1);
`endif
    // clean victim goes straight to fill; written-back data comes home
    do_req("t3_back", 1'b0, 32'h13, 32'h0, rd, lat);
    chk("t3_clean_no_wb", 512'(wb_seen), 512'd1);
    chk("t3_back_fill_addr", 512'(last_fill_addr), 512'h001);
    chk("t3_back_rdata", 512'(rd), 512'h12345678);

    // T4: store miss at max index / last offset, then dirty eviction by max tag
    ws = wb_seen;
    do_req("t4_st", 1'b1, 32'h0000FFFF, 32'hCAFEF00D, rd, lat);
    chk("t4_st_no_wb", 512'(wb_seen), 512'(ws));
    chk("t4_st_fill_addr", 512'(last_fill_addr), 512'hFFF);
    chk("t4_st_rdata_zero", 512'(rd), 512'd0);
    do_req("t4_ld15", 1'b0, 32'h0000FFFF, 32'h0, rd, lat);
    chk("t4_ld15_rdata", 512'(rd), 512'hCAFEF00D);
    chk("t4_ld15_lat", 512'(lat), 512'd2);
    do_req("t4_ld0", 1'b0, 32'h0000FFF0, 32'h0, rd, lat);
    chk("t4_ld0_rdata", 512'(rd), 512'hC00FFF00);
    do_req("t4_evict", 1'b0, 32'hFFFFFFF0, 32'h0, rd, lat);
    chk("t4_wb_addr", 512'(last_wb_addr), 512'hFFF);
    blk = last_wb_blk;
    chk("t4_wb_lsb_word", 512'(blk[31:0]), 512'hCAFEF00D);
    chk("t4_fill_addr_maxtag", 512'(last_fill_addr), 512'hFFFFFFF);
    chk("t4_evict_rdata", 512'(rd), 512'hCFFFFF00);

    // T5: slow memory; outputs stable, second request held off
    ack_delay = 20;
    acc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_wdata = '0;
    for (int n = 0; n < 200; n++) begin
      if (req_ready) begin
        @(posedge clk);
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    #1 req_addr = 32'h50;
    chk("t5_accepted", 512'(acc), 512'd1);
    @(negedge clk);
    stable = 1;
    repeat (15) begin
      @(negedge clk);
      if (!(mem_req === 1'b1 && mem_addr === 28'h2 && mem_we === 1'b0 && req_ready === 1'b0))
        stable = 0;
    end
    chk("t5_stable", 512'(stable), 512'd1);
    req_valid = 1'b0;
    wait_resp("t5", rd, lat);
    chk("t5_rdata", 512'(rd), 512'hC0000200);
    chk("t5_second_not_taken", 512'(last_fill_addr), 512'h2);
    ack_delay = 0;
    fs = fill_seen;
    @(negedge clk);
    stray_req++;
    repeat (2) @(negedge clk);
    chk("t5_stray_mem_req", 512'(mem_req), 512'd0);
    chk("t5_stray_ready", 512'(req_ready), 512'd1);
    chk("t5_stray_resp", 512'(resp_valid), 512'd0);
    do_req("t5_hit", 1'b0, 32'h20, 32'h0, rd, lat);
    chk("t5_hit_rdata", 512'(rd), 512'hC0000200);
    chk("t5_hit_lat", 512'(lat), 512'd2);
    chk("t5_hit_no_fill", 512'(fill_seen), 512'(fs));

    // T6: reset in the middle of a fill
    ack_delay = 1000;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h30;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_in_fill", 512'(mem_req), 512'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_mem_req", 512'(mem_req), 512'd0);
    chk("t6_rst_ready", 512'(req_ready), 512'd1);
`ifdef DCACHE_STATS_EN
    chk("t6_rst_hits", 512'(hit_count), 512'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    fs = fill_seen;
    do_req("t6_reload", 1'b0, 32'h30, 32'h0, rd, lat);
    chk("t6_reload_miss", 512'(fill_seen), 512'(fs + 1));
    chk("t6_reload_rdata", 512'(rd), 512'hC0000300);
    do_req("t6_line1", 1'b0, 32'h10, 32'h0, rd, lat);
    chk("t6_line1_miss", 512'(fill_seen), 512'(fs + 2));
    chk("t6_line1_rdata", 512'(rd), 512'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
